hc4_ram_arbiter: RTL and testbench

- Two-port arbiter and bus sequencer for the shared 4-bit x 256-nibble asynchronous RAM, which also serves as the register file.
- Port 0 is the HC4 core's memory request; port 1 is the loader/debug requester.
- Serialises accesses, generates address_bus, data_bus, nRAM_RD and nRAM_WR with setup/strobe/hold timing, and returns read data plus a one-cycle ack to the owning port.

---
 rtl/hc4_ram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_hc4_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc4_ram_arbiter.sv
// hc4_ram_arbiter: two-port round-robin arbiter and bus sequencer for the
// shared 4-bit x 256-nibble asynchronous RAM.
//
// Handshake (both ports): a requester raises reqN with weN/addrN/wdataN
// stable and keeps them until ackN. ackN is a single-cycle pulse in the HOLD
// cycle, and rdataN is valid from that cycle on. A req still high in the
// cycle after ack is a new request. Dropping req after the grant does not
// cancel the access; it completes and still acks.
//
// Every output is registered. The next-state logic computes the value each
// output takes in the following cycle. This keeps input-to-output paths out
// of the RAM bus timing.
module hc4_ram_arbiter #(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 4,
   parameter int STROBE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] address_bus,
   inout  wire  [DATA_W-1:0] data_bus,
   output logic              nRAM_RD,
   output logic              nRAM_WR,
   output logic              busy,
   output logic              grant,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // A strobe of N cycles means the counter is loaded with N-1 and the
   // STROBE state exits when the counter reaches zero.
   localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic              last, last_n;
   logic              grant_q, grant_n;
   logic              we_q, we_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic [ADDR_W-1:0] abus_q, abus_n;
   logic              drive, drive_n;
   logic              nrd_q, nrd_n;
   logic              nwr_q, nwr_n;
   logic              ack0_q, ack0_n;
   logic              ack1_q, ack1_n;
   logic              busy_q, busy_n;
   logic [DATA_W-1:0] rdata0_q, rdata0_n;
   logic [DATA_W-1:0] rdata1_q, rdata1_n;
   logic              pick;

   // The tri-state data driver is enabled only from SETUP through HOLD of a write.
   assign data_bus    = drive ? wdata_q : {DATA_W{1'bz}};
   assign address_bus = abus_q;
   assign nRAM_RD     = nrd_q;
   assign nRAM_WR     = nwr_q;
   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;
   assign busy        = busy_q;
   assign grant       = grant_q;
   assign fsm_state   = state;

   // Next-state logic and next values of every registered output.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      last_n   = last;
      grant_n  = grant_q;
      we_n     = we_q;
      wdata_n  = wdata_q;
      abus_n   = abus_q;
      drive_n  = drive;
      nrd_n    = 1'b1;
      nwr_n    = 1'b1;
      ack0_n   = 1'b0;
      ack1_n   = 1'b0;
      busy_n   = busy_q;
      rdata0_n = rdata0_q;
      rdata1_n = rdata1_q;
      pick     = 1'b0;

      case (state)
         IDLE: begin
            drive_n = 1'b0;
            busy_n  = 1'b0;
            if (req0 || req1) begin
               // On a tie the port that did not win last time is chosen.
               pick    = (req0 && req1) ? ~last : req1;
               grant_n = pick;
               last_n  = pick;
               we_n    = pick ? we1 : we0;
               wdata_n = pick ? wdata1 : wdata0;
               abus_n  = pick ? addr1 : addr0;
               drive_n = pick ? we1 : we0;
               busy_n  = 1'b1;
               state_n = SETUP;
            end
         end
         SETUP: begin
            cnt_n   = CNT_LOAD;
            nrd_n   = we_q;
            nwr_n   = ~we_q;
            state_n = STROBE;
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               // The read data is taken on the edge that ends the strobe.
               if (!we_q) begin
                  if (grant_q) rdata1_n = data_bus;
                  else         rdata0_n = data_bus;
               end
               ack0_n  = ~grant_q;
               ack1_n  = grant_q;
               state_n = HOLD;
            end else begin
               cnt_n = cnt - 4'd1;
               nrd_n = we_q;
               nwr_n = ~we_q;
            end
         end
         HOLD: begin
            drive_n = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            drive_n = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers. Reset aborts any access at once: strobes
   // are released, the driver is disabled, and no ack is issued.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         last     <= 1'b1;
         grant_q  <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         abus_q   <= '0;
         drive    <= 1'b0;
         nrd_q    <= 1'b1;
         nwr_q    <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         last     <= last_n;
         grant_q  <= grant_n;
         we_q     <= we_n;
         wdata_q  <= wdata_n;
         abus_q   <= abus_n;
         drive    <= drive_n;
         nrd_q    <= nrd_n;
         nwr_q    <= nwr_n;
         ack0_q   <= ack0_n;
         ack1_q   <= ack1_n;
         busy_q   <= busy_n;
         rdata0_q <= rdata0_n;
         rdata1_q <= rdata1_n;
      end
   end

endmodule

// File: tb/tb_hc4_ram_arbiter.sv
// Testbench for hc4_ram_arbiter: directed scenarios plus mixed traffic
// against a behavioural asynchronous RAM.
module tb_hc4_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (STROBE_CYCLES = 1) ----------------
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0;
  logic [3:0] wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, nRAM_RD, nRAM_WR, busy, grant;
  logic [3:0] rdata0, rdata1;
  logic [7:0] address_bus;
  logic [1:0] fsm_state;
  wire  [3:0] data_bus;

  hc4_ram_arbiter #(.ADDR_W(8), .DATA_W(4), .STROBE_CYCLES(1)) dut (
    .clk(clk), .nReset(nReset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .address_bus(address_bus), .data_bus(data_bus), .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR),
    .busy(busy), .grant(grant), .fsm_state(fsm_state)
  );

  // RAM model: reads drive the bus while nRAM_RD is low; writes land on a
  // clock edge sampled while nRAM_WR is low. Preload shares the same process.
  logic [3:0] mem_a [256];
  logic       pre_en = 0;
  logic [7:0] pre_addr = 0;
  logic [3:0] pre_data = 0;
  assign data_bus = !nRAM_RD ? mem_a[address_bus] : 4'bz;
  always @(posedge clk) begin
    if (pre_en) mem_a[pre_addr] <= pre_data;
    else if (!nRAM_WR) mem_a[address_bus] <= data_bus;
  end

  // ---------------- second DUT (STROBE_CYCLES = 3) ----------------
  logic       b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
  logic [7:0] b_addr0 = 0, b_addr1 = 0;
  logic [3:0] b_wdata0 = 0, b_wdata1 = 0;
  logic       b_ack0, b_ack1, b_nRAM_RD, b_nRAM_WR, b_busy, b_grant;
  logic [3:0] b_rdata0, b_rdata1;
  logic [7:0] b_address_bus;
  logic [1:0] b_fsm_state;
  wire  [3:0] b_data_bus;
  logic [3:0] b_rdval = 4'h9;
  assign b_data_bus = !b_nRAM_RD ? b_rdval : 4'bz;

  hc4_ram_arbiter #(.ADDR_W(8), .DATA_W(4), .STROBE_CYCLES(3)) dut3 (
    .clk(clk), .nReset(nReset),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .address_bus(b_address_bus), .data_bus(b_data_bus), .nRAM_RD(b_nRAM_RD), .nRAM_WR(b_nRAM_WR),
    .busy(b_busy), .grant(b_grant), .fsm_state(b_fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] ref_mem [16];
  logic [3:0] exp_q[$];

  // ---------------- bus invariant monitor ----------------
  always @(negedge clk) begin
    if (nReset) begin
      checks++;
      if (!nRAM_RD && !nRAM_WR) begin
        errors++; $display("FAIL inv_strobes: nRAM_RD=%b nRAM_WR=%b required not both low", nRAM_RD, nRAM_WR);
      end
      checks++;
      if (ack0 && ack1) begin
        errors++; $display("FAIL inv_acks: ack0=%b ack1=%b required not both high", ack0, ack1);
      end
      checks++;
      if (dut.drive && (!nRAM_RD || fsm_state == 2'd0)) begin
        errors++; $display("FAIL inv_drive: drive=1 with nRAM_RD=%b state=%0d", nRAM_RD, fsm_state);
      end
      checks++;
      if (b_nRAM_RD === 1'b0 && b_nRAM_WR === 1'b0) begin
        errors++; $display("FAIL inv_strobes3: both strobes low");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [7:0] a, input logic [3:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 0;
  endtask

  // One access on port p, started in an IDLE cycle. Returns the cycle count
  // to ack (1 = next cycle), the number of cycles with a strobe low, and the
  // port's rdata at ack. Leaves the DUT back in IDLE.
  task automatic access(input bit p, input logic w, input logic [7:0] a, input logic [3:0] d,
                        output int lat, output int low, output logic [3:0] rd);
    if (!p) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    lat = 0; low = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!nRAM_RD || !nRAM_WR) low++;
    end while (!(p ? ack1 : ack0) && lat < 30);
    rd = p ? rdata1 : rdata0;
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    nReset = 0; req0 = 0; req1 = 0; b_req0 = 0; b_req1 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (address_bus !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", address_bus); end
    checks++; if (nRAM_RD !== 1'b1) begin errors++; $display("FAIL reset_nrd: got %b want 1", nRAM_RD); end
    checks++; if (nRAM_WR !== 1'b1) begin errors++; $display("FAIL reset_nwr: got %b want 1", nRAM_WR); end
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b%b want 00", ack0, ack1); end
    checks++; if ({rdata0, rdata1} !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h %h want 0 0", rdata0, rdata1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    nReset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int lat, low;
    logic [3:0] rd;
    access(0, 1, 8'h3A, 4'hC, lat, low, rd);
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++; if (low != 1) begin errors++; $display("FAIL wr_strobe_len: got %0d want 1", low); end
    checks++; if (mem_a[8'h3A] !== 4'hC) begin errors++; $display("FAIL wr_mem: got %h want c", mem_a[8'h3A]); end
    checks++; if (address_bus !== 8'h3A) begin errors++; $display("FAIL addr_hold: got %h want 3a", address_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    access(0, 0, 8'h3A, 4'h0, lat, low, rd);
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
    checks++; if (low != 1) begin errors++; $display("FAIL rd_strobe_len: got %0d want 1", low); end
    checks++; if (rd !== 4'hC) begin errors++; $display("FAIL rd_data: got %h want c", rd); end
    access(0, 1, 8'h3A, 4'h5, lat, low, rd);
    checks++; if (rdata0 !== 4'hC) begin errors++; $display("FAIL rdata_hold_on_write: got %h want c", rdata0); end
  endtask

  task automatic test_tie;
    int a0c, a1c;
    logic [3:0] r0, r1;
    logic g1;
    preload(8'h10, 4'h5);
    preload(8'h20, 4'hA);
    a0c = -1; a1c = -1; r0 = 0; r1 = 0; g1 = 0;
    req0 = 1; we0 = 0; addr0 = 8'h10;
    req1 = 1; we1 = 0; addr1 = 8'h20;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ack0) begin a0c = c; r0 = rdata0; req0 = 0; end
      if (ack1) begin a1c = c; r1 = rdata1; g1 = grant; req1 = 0; end
    end
    req0 = 0; req1 = 0;
    checks++; if (a0c != 3) begin errors++; $display("FAIL tie_ack0_cycle: got %0d want 3", a0c); end
    checks++; if (r0 !== 4'h5) begin errors++; $display("FAIL tie_rdata0: got %h want 5", r0); end
    checks++; if (a1c != 7) begin errors++; $display("FAIL tie_ack1_cycle: got %0d want 7", a1c); end
    checks++; if (r1 !== 4'hA) begin errors++; $display("FAIL tie_rdata1: got %h want a", r1); end
    checks++; if (g1 !== 1'b1) begin errors++; $display("FAIL tie_grant1: got %b want 1", g1); end
  endtask

  task automatic test_round_robin;
    int n, prev;
    logic e;
    n = 0; prev = 0;
    req0 = 1; we0 = 0; addr0 = 8'h01;
    req1 = 1; we1 = 0; addr1 = 8'h02;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) begin
        e = n[0];
        checks++; if (ack1 !== e) begin errors++; $display("FAIL rr_port_%0d: ack1=%b want %b", n, ack1, e); end
        checks++; if (grant !== e) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", n, grant, e); end
        checks++; if (c - prev != (n == 0 ? 3 : 4)) begin errors++; $display("FAIL rr_spacing_%0d: got %0d want %0d", n, c - prev, (n == 0 ? 3 : 4)); end
        prev = c;
        n++;
        if (n == 6) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    checks++; if (n != 6) begin errors++; $display("FAIL rr_count: got %0d want 6", n); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_long_strobe;
    int a1c;
    a1c = -1;
    b_req1 = 1; b_we1 = 0; b_addr1 = 8'h55; b_rdval = 4'h9;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (b_nRAM_RD !== ((c >= 2 && c <= 4) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL ls_nrd_c%0d: got %b want %b", c, b_nRAM_RD, ((c >= 2 && c <= 4) ? 1'b0 : 1'b1));
      end
      if (c <= 5) begin
        checks++;
        if (b_address_bus !== 8'h55) begin errors++; $display("FAIL ls_addr_c%0d: got %h want 55", c, b_address_bus); end
      end
      if (b_ack1 && a1c < 0) begin a1c = c; b_req1 = 0; end
    end
    b_req1 = 0;
    checks++; if (a1c != 5) begin errors++; $display("FAIL ls_ack1_cycle: got %0d want 5", a1c); end
    checks++; if (b_rdata1 !== 4'h9) begin errors++; $display("FAIL ls_rdata1: got %h want 9", b_rdata1); end
  endtask

  task automatic test_reset_abort;
    int lat, low;
    logic [3:0] rd;
    preload(8'h80, 4'h2);
    req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 4'h7;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (nRAM_WR !== 1'b0) begin errors++; $display("FAIL abort_in_strobe: nRAM_WR=%b want 0", nRAM_WR); end
    nReset = 0; req1 = 0;
    @(posedge clk); #1;
    checks++; if (nRAM_WR !== 1'b1) begin errors++; $display("FAIL abort_nwr: got %b want 1", nRAM_WR); end
    checks++; if (dut.drive !== 1'b0) begin errors++; $display("FAIL abort_drive: got %b want 0", dut.drive); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL abort_no_ack_%0d: got %b want 0", c, ack1); end
      @(posedge clk); #1;
    end
    nReset = 1;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL abort_no_ack_after: got %b want 0", ack1); end
    access(1, 1, 8'h80, 4'h7, lat, low, rd);
    checks++; if (lat != 3) begin errors++; $display("FAIL retry_latency: got %0d want 3", lat); end
    access(1, 0, 8'h80, 4'h0, lat, low, rd);
    checks++; if (rd !== 4'h7) begin errors++; $display("FAIL retry_read: got %h want 7", rd); end
  endtask

  task automatic test_random;
    int lat, low;
    logic [3:0] rd, e, d;
    logic [7:0] a;
    bit p;
    logic w;
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_a[i];
    for (int i = 0; i < 24; i++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      access(p, w, a, d, lat, low, rd);
      checks++; if (lat != 3) begin errors++; $display("FAIL rand_latency_%0d: got %0d want 3", i, lat); end
      if (w) ref_mem[a[3:0]] = d;
      else begin
        exp_q.push_back(ref_mem[a[3:0]]);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL rand_read_%0d: port %0d addr %h got %h want %h", i, p, a, rd, e); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_write_read;
    test_reset;
    test_tie;
    test_round_robin;
    test_long_strobe;
    test_reset_abort;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
